// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect/stall handling and IF/ID register.
// The IF/ID register also tracks loaded-instruction count and a sticky misaligned-redirect flag.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_PC,
   output logic [31:0] IF_ID_PCPlus4,
   output logic [31:0] IF_ID_Instruction,
   output logic        IF_ID_Valid,
   output logic        MisalignedErr,
   output logic [31:0] FetchCount
);

   localparam logic [31:0] NOP = 32'h00000013;

   // Only the word address is stored, so PC[1:0] is zero by construction.
   logic [29:0] pc_word;
   logic [31:0] pc_plus4;
   logic        redirect_bad;

   assign PC           = {pc_word, 2'b00};
   assign pc_plus4     = PC + 32'd4;
   assign redirect_bad = BranchTaken && (BranchTarget[1:0] != 2'b00);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pc_word           <= RESET_PC[31:2];
         IF_ID_PC          <= 32'h0;
         IF_ID_PCPlus4     <= 32'h0;
         IF_ID_Instruction <= NOP;
         IF_ID_Valid       <= 1'b0;
         MisalignedErr     <= 1'b0;
         FetchCount        <= 32'h0;
      end else begin
         if (BranchTaken)
            pc_word <= BranchTarget[31:2];
         else if (!Stall)
            pc_word <= pc_word + 30'd1;

         if (redirect_bad)
            MisalignedErr <= 1'b1;

         // A redirect squashes the word fetched this cycle, even under stall.
         if (Flush || BranchTaken) begin
            IF_ID_Valid       <= 1'b0;
            IF_ID_Instruction <= NOP;
         end else if (!Stall) begin
            IF_ID_PC          <= PC;
            IF_ID_PCPlus4     <= pc_plus4;
            IF_ID_Instruction <= Instruction;
            IF_ID_Valid       <= 1'b1;
            FetchCount        <= FetchCount + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a random
// run compared against a cycle-level reference model.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, br = 1'b0;
   logic [31:0] tgt = 32'h0;
   logic [31:0] instr, pc, ifpc, ifpc4, ifinstr, cnt;
   logic        ifvalid, err;

   logic        rst1 = 1'b1;
   logic [31:0] instr1, pc1, ifpc1, ifpc4_1, ifinstr1, cnt1;
   logic        ifvalid1, err1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a >> 2) + 32'd1;
   endfunction

   assign instr  = mem_word(pc);
   assign instr1 = mem_word(pc1);

   fetch_stage dut (
      .Clock(clk), .Reset(rst), .Stall(stall), .Flush(flush),
      .BranchTaken(br), .BranchTarget(tgt), .Instruction(instr),
      .PC(pc), .IF_ID_PC(ifpc), .IF_ID_PCPlus4(ifpc4),
      .IF_ID_Instruction(ifinstr), .IF_ID_Valid(ifvalid),
      .MisalignedErr(err), .FetchCount(cnt)
   );

   fetch_stage #(.RESET_PC(32'hFFFFFFF8)) dut_wrap (
      .Clock(clk), .Reset(rst1), .Stall(1'b0), .Flush(1'b0),
      .BranchTaken(1'b0), .BranchTarget(32'h0), .Instruction(instr1),
      .PC(pc1), .IF_ID_PC(ifpc1), .IF_ID_PCPlus4(ifpc4_1),
      .IF_ID_Instruction(ifinstr1), .IF_ID_Valid(ifvalid1),
      .MisalignedErr(err1), .FetchCount(cnt1)
   );

   // Reference model state
   logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_cnt;
   logic        m_valid, m_err;

   // Apply one cycle of inputs and advance the model by the same edge.
   task automatic drive(input logic r, s, f, b, input logic [31:0] t);
      logic [31:0] cur;
      @(negedge clk);
      rst = r; stall = s; flush = f; br = b; tgt = t;
      @(posedge clk);
      cur = m_pc;
      if (r) begin
         m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
         m_instr = NOP; m_valid = 1'b0; m_err = 1'b0; m_cnt = 32'h0;
      end else begin
         if (b) begin
            m_pc = (t / 4) * 4;
            if (t % 4 != 0) m_err = 1'b1;
         end else if (!s) begin
            m_pc = cur + 32'd4;
         end
         if (f || b) begin
            m_valid = 1'b0; m_instr = NOP;
         end else if (!s) begin
            m_ifpc = cur; m_ifpc4 = cur + 32'd4;
            m_instr = mem_word(cur); m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 32'h0);
      drive(1, 1, 1, 1, 32'h33);
      vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
      vectors++; if (ifpc !== 32'h0 || ifpc4 !== 32'h0) begin miscompares++; $display("FAIL reset_ifpc got %h/%h want 0/0", ifpc, ifpc4); end
      vectors++; if (ifinstr !== NOP) begin miscompares++; $display("FAIL reset_instr got %h want %h", ifinstr, NOP); end
      vectors++; if (ifvalid !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_flags got v=%b e=%b want 0/0", ifvalid, err); end
      vectors++; if (cnt !== 32'h0) begin miscompares++; $display("FAIL reset_count got %h want 0", cnt); end
   endtask

   task automatic test_sequential();
      drive(1, 0, 0, 0, 32'h0);
      drive(0, 0, 0, 0, 32'h0);
      vectors++; if (pc !== 32'h4 || ifvalid !== 1'b1) begin miscompares++; $display("FAIL seq_first got pc=%h v=%b want 4/1", pc, ifvalid); end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) drive(0, 0, 0, 0, 32'h0);
         vectors++;
         if (ifpc !== 32'(i * 4) || ifinstr !== 32'(i + 1) || ifvalid !== 1'b1 || ifpc4 !== 32'(i * 4 + 4)) begin
            miscompares++;
            $display("FAIL seq_%0d got pc=%h pc4=%h ins=%h v=%b want %h/%h/%h/1", i, ifpc, ifpc4, ifinstr, ifvalid, i * 4, i * 4 + 4, i + 1);
         end
      end
      vectors++; if (cnt !== 32'd4) begin miscompares++; $display("FAIL seq_count got %0d want 4", cnt); end
   endtask

   task automatic test_stall();
      drive(1, 0, 0, 0, 32'h0);
      drive(0, 0, 0, 0, 32'h0);
      drive(0, 0, 0, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 32'h0);
         vectors++;
         if (pc !== 32'h8 || ifpc !== 32'h4 || ifinstr !== 32'h2 || ifvalid !== 1'b1 || cnt !== 32'd2) begin
            miscompares++;
            $display("FAIL stall_%0d got pc=%h ifpc=%h ins=%h v=%b cnt=%0d want 8/4/2/1/2", i, pc, ifpc, ifinstr, ifvalid, cnt);
         end
      end
      drive(0, 0, 0, 0, 32'h0);
      vectors++;
      if (pc !== 32'hC || ifpc !== 32'h8 || ifinstr !== 32'h3 || cnt !== 32'd3) begin
         miscompares++;
         $display("FAIL stall_release got pc=%h ifpc=%h ins=%h cnt=%0d want C/8/3/3", pc, ifpc, ifinstr, cnt);
      end
   endtask

   task automatic test_redirect_over_stall();
      drive(0, 1, 0, 1, 32'h100);
      vectors++;
      if (pc !== 32'h100 || ifvalid !== 1'b0 || ifinstr !== NOP || ifpc !== 32'h8) begin
         miscompares++;
         $display("FAIL redirect got pc=%h v=%b ins=%h ifpc=%h want 100/0/13/8", pc, ifvalid, ifinstr, ifpc);
      end
      drive(0, 0, 0, 0, 32'h0);
      vectors++;
      if (ifpc !== 32'h100 || ifinstr !== 32'h41 || ifvalid !== 1'b1 || ifpc4 !== 32'h104) begin
         miscompares++;
         $display("FAIL redirect_next got ifpc=%h ins=%h v=%b pc4=%h want 100/41/1/104", ifpc, ifinstr, ifvalid, ifpc4);
      end
   endtask

   task automatic test_flush();
      drive(0, 1, 1, 0, 32'h0);
      vectors++;
      if (pc !== 32'h104 || ifvalid !== 1'b0 || ifinstr !== NOP || ifpc !== 32'h100) begin
         miscompares++;
         $display("FAIL flush_stall got pc=%h v=%b ins=%h ifpc=%h want 104/0/13/100", pc, ifvalid, ifinstr, ifpc);
      end
      drive(0, 0, 1, 0, 32'h0);
      vectors++;
      if (pc !== 32'h108 || ifvalid !== 1'b0 || cnt !== 32'd4) begin
         miscompares++;
         $display("FAIL flush_run got pc=%h v=%b cnt=%0d want 108/0/4", pc, ifvalid, cnt);
      end
   endtask

   task automatic test_misaligned();
      drive(0, 0, 0, 1, 32'h102);
      vectors++;
      if (pc !== 32'h100 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL misalign got pc=%h err=%b want 100/1", pc, err);
      end
      for (int i = 0; i < 10; i++) begin
         drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
         vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL misalign_sticky_%0d got %b want 1", i, err); end
      end
      drive(0, 0, 0, 1, 32'h200);
      vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL misalign_aligned got %b want 1", err); end
      drive(1, 0, 0, 0, 32'h0);
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL misalign_clear got %b want 0", err); end
   endtask

   task automatic test_reset_mid();
      drive(0, 0, 0, 0, 32'h0);
      drive(0, 0, 0, 1, 32'h3);
      drive(1, 1, 0, 1, 32'h200);
      vectors++;
      if (pc !== 32'h0 || ifpc !== 32'h0 || ifpc4 !== 32'h0 || ifinstr !== NOP || ifvalid !== 1'b0 || err !== 1'b0 || cnt !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_mid got pc=%h ifpc=%h pc4=%h ins=%h v=%b e=%b cnt=%h", pc, ifpc, ifpc4, ifinstr, ifvalid, err, cnt);
      end
   endtask

   task automatic test_random();
      drive(1, 0, 0, 0, 32'h0);
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
               ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFF) : $urandom);
         vectors++;
         if (pc !== m_pc || ifpc !== m_ifpc || ifpc4 !== m_ifpc4 || ifinstr !== m_instr ||
             ifvalid !== m_valid || err !== m_err || cnt !== m_cnt) begin
            miscompares++;
            $display("FAIL random_%0d got pc=%h ifpc=%h pc4=%h ins=%h v=%b e=%b cnt=%h want %h %h %h %h %b %b %h",
                     i, pc, ifpc, ifpc4, ifinstr, ifvalid, err, cnt,
                     m_pc, m_ifpc, m_ifpc4, m_instr, m_valid, m_err, m_cnt);
         end
      end
   endtask

   task automatic test_pc_wrap();
      @(negedge clk); rst1 = 1'b1;
      @(posedge clk); #1;
      vectors++; if (pc1 !== 32'hFFFFFFF8 || ifvalid1 !== 1'b0) begin miscompares++; $display("FAIL wrap_reset got %h v=%b want FFFFFFF8/0", pc1, ifvalid1); end
      @(negedge clk); rst1 = 1'b0;
      @(posedge clk); #1;
      vectors++; if (pc1 !== 32'hFFFFFFFC || ifpc1 !== 32'hFFFFFFF8) begin miscompares++; $display("FAIL wrap_1 got pc=%h ifpc=%h want FFFFFFFC/FFFFFFF8", pc1, ifpc1); end
      @(posedge clk); #1;
      vectors++;
      if (pc1 !== 32'h0 || ifpc1 !== 32'hFFFFFFFC || ifpc4_1 !== 32'h0 || ifinstr1 !== 32'h40000000) begin
         miscompares++;
         $display("FAIL wrap_2 got pc=%h ifpc=%h pc4=%h ins=%h want 0/FFFFFFFC/0/40000000", pc1, ifpc1, ifpc4_1, ifinstr1);
      end
      @(posedge clk); #1;
      vectors++; if (ifpc1 !== 32'h0 || ifinstr1 !== 32'h1 || cnt1 !== 32'd3) begin miscompares++; $display("FAIL wrap_3 got ifpc=%h ins=%h cnt=%0d want 0/1/3", ifpc1, ifinstr1, cnt1); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_over_stall();
      test_flush();
      test_misaligned();
      test_reset_mid();
      test_random();
      test_pc_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
